// File: rtl/mult_32.sv
// Iterative shift-add 32x32 multiplier for MIPS MULT/MULTU.
// One partial product per cycle through a single shared adder; HI/LO are written once per operation.
module mult_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]      LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   ONE_W   = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W  = (2*WIDTH)'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        FIXUP   = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   p_hi;
    logic [WIDTH-1:0]   p_lo;
    logic               neg;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;

    // The most negative value maps onto itself, which is exactly 2^(WIDTH-1) read as unsigned.
    always_comb begin
        a_mag = (is_signed && a[WIDTH-1]) ? (~a + ONE_W) : a;
        b_mag = (is_signed && b[WIDTH-1]) ? (~b + ONE_W) : b;
        sum   = p_lo[0] ? ({1'b0, p_hi} + {1'b0, mcand}) : {1'b0, p_hi};
        prod  = neg ? (~{p_hi, p_lo} + ONE_2W) : {p_hi, p_lo};
    end

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            mcand <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
            neg   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= a_mag;
                        p_hi  <= '0;
                        p_lo  <= b_mag;
                        neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        count <= '0;
                        busy  <= 1'b1;
                        state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    // Carry out of the add becomes the new MSB as the pair shifts right.
                    p_hi  <= sum[WIDTH:1];
                    p_lo  <= {sum[0], p_lo[WIDTH-1:1]};
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state <= FIXUP;
                    end
                end
                FIXUP: begin
                    hi    <= prod[2*WIDTH-1:WIDTH];
                    lo    <= prod[WIDTH-1:0];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_32.sv
// Randomized bench for mult_32 against a plain-arithmetic 64-bit product model.
// Covers latency, busy/done timing, ignored restarts, continuous start and mid-operation reset.
module tb_mult_32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  dbg_state;

    int n_checks;
    int n_errors;
    logic [63:0] exp_q[$];
    logic [63:0] last_prod;

    mult_32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic s, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    // One full operation; poke>0 re-asserts start (a=b=2) so it is sampled at edge E<poke>.
    task automatic do_op(input logic s, input logic [31:0] x, input logic [31:0] y, input int poke);
        int lat;
        bit seen;
        logic [63:0] exp;
        @(negedge clk);
        start = 1'b1; is_signed = s; a = x; b = y;
        exp_q.push_back(model(s, x, y));
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; is_signed = 1'($urandom_range(0, 1));
        check("busy_after_start", {63'b0, busy}, 64'd1);
        lat = 0;
        seen = 0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            if (poke > 0 && lat == poke - 1) begin
                start = 1'b1; a = 32'd2; b = 32'd2; is_signed = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            if (done) begin
                seen = 1;
                exp = exp_q.pop_front();
                check("latency", 64'(lat), 64'd33);
                check("busy_at_done", {63'b0, busy}, 64'd0);
                check("product", {hi, lo}, exp);
                last_prod = exp;
            end else begin
                check("busy_in_flight", {63'b0, busy}, 64'd1);
                if (lat == 16) check("hold_hilo", {hi, lo}, last_prod);
            end
        end
        check("done_seen", {63'b0, seen}, 64'd1);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check("done_one_cycle", {63'b0, done}, 64'd0);
        check("hilo_after_done", {hi, lo}, last_prod);
    endtask

    initial begin
        int first;
        int second;
        bit seen_done;
        n_checks = 0;
        n_errors = 0;
        last_prod = '0;
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        #3;
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_state", {62'b0, dbg_state}, 64'd0);
        #20;
        @(negedge clk); rst_n = 1'b1;

        // directed cases
        do_op(1'b0, 32'd6, 32'd7, 0);
        check("dir_6x7", {hi, lo}, 64'h0000_0000_0000_002A);
        do_op(1'b1, 32'hFFFF_FFFD, 32'd5, 0);
        check("dir_m3x5", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("dir_umax", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        do_op(1'b1, 32'h8000_0000, 32'h8000_0000, 0);
        check("dir_smin_sq", {hi, lo}, 64'h4000_0000_0000_0000);
        do_op(1'b1, 32'h8000_0000, 32'd1, 0);
        check("dir_smin_x1", {hi, lo}, 64'hFFFF_FFFF_8000_0000);
        do_op(1'b0, 32'd6, 32'd7, 10);
        check("restart_ignored", {hi, lo}, 64'h0000_0000_0000_002A);

        // randomized operations
        for (int i = 0; i < 16; i++) begin
            logic [31:0] x;
            logic [31:0] y;
            x = $urandom;
            y = $urandom;
            if (i == 3) x = 32'd0;
            if (i == 5) y = 32'hFFFF_FFFF;
            do_op(1'($urandom_range(0, 1)), x, y, 0);
        end

        // start held high across two operations
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; a = 32'd6; b = 32'd7;
        @(posedge clk); #1;
        a = 32'h0000_1234; b = 32'h0000_0010;
        first = -1;
        second = -1;
        for (int e = 1; e <= 80 && second < 0; e++) begin
            @(posedge clk); #1;
            if (done) begin
                if (first < 0) begin
                    first = e;
                    check("cont_first", {hi, lo}, 64'd42);
                end else begin
                    second = e;
                    check("cont_second", {hi, lo}, model(1'b0, 32'h0000_1234, 32'h0000_0010));
                end
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("cont_first_lat", 64'(first), 64'd33);
        check("cont_spacing", 64'(second - first), 64'd34);
        last_prod = model(1'b0, 32'h0000_1234, 32'h0000_0010);
        @(posedge clk); #1;

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; a = 32'd6; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_done", {63'b0, done}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_state", {62'b0, dbg_state}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_prod = '0;
        seen_done = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk); #1;
            if (done) seen_done = 1;
        end
        check("abort_no_done", {63'b0, seen_done}, 64'd0);
        do_op(1'b0, 32'd6, 32'd7, 0);
        check("after_abort_6x7", {hi, lo}, 64'h0000_0000_0000_002A);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mult_32.md
Name: mult_32

Overview:
Multi-cycle 32x32 multiplier producing a 64-bit product in HI/LO, for MIPS MULT/MULTU.
- Iterative shift-add, one partial product per cycle, so one 32-bit adder is shared across all iterations.
- Sits beside the ALU; the datapath starts it, stalls on busy, and writes HI/LO when done pulses.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH bits; iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start
a  input  WIDTH  multiplicand; sampled with start
b  input  WIDTH  multiplier; sampled with start
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse: hi/lo valid
hi  output  WIDTH  upper product half
lo  output  WIDTH  lower product half

Behaviour:
- Reset is asynchronous and active-low.
  - While rst_n=0: state=IDLE, busy=0, done=0, hi=0, lo=0; internal counter, accumulator, operand registers and sign flag cleared.
  - Reset asserted mid-operation aborts the operation; no done pulse is produced for it.
- States:
  - IDLE -> COMPUTE -> FIXUP -> IDLE.
  - IDLE is left only when start=1 at a clock edge.
- Edge E0 (start=1 in IDLE):
  - Latch magnitudes: |a| and |b| when is_signed=1, raw a and b otherwise.
  - neg = is_signed & (a[31]^b[31]).
  - Accumulator {P_hi, P_lo} = {0, |b|}, count=0, state=COMPUTE, busy=1.
  - Magnitude of 0x80000000 is 0x80000000, treated as unsigned 2^31.
- COMPUTE, edges E1..E32, one iteration per edge:
  - If P_lo[0]=1, sum = P_hi + mcand (33-bit, carry kept); else sum = {0, P_hi}.
  - Shift right: {P_hi, P_lo} = {sum, P_lo} >> 1.
  - count increments.
  - At count = WIDTH-1, next state = FIXUP.
- FIXUP, edge E33:
  - Product = neg ? (~{P_hi,P_lo} + 1) : {P_hi,P_lo}, full 64-bit two's-complement negation.
  - Write hi/lo, set done=1, set busy=0, state=IDLE.
- Latency:
  - done is high in the cycle following E33, i.e. 33 edges after the start edge.
  - done lasts exactly one cycle.
  - busy is high from after E0 through the cycle ending at E33.
- hi/lo:
  - Change only at FIXUP (or reset).
  - Hold their value until the next FIXUP; they do not change during a subsequent operation's COMPUTE.
- start handling:
  - start while busy=1 is ignored; operands are not re-sampled and no queueing occurs.
  - start in the same cycle done is high is accepted (state is IDLE); done still deasserts next cycle.
  - Back-to-back operations therefore have a 34-cycle throughput.
- a, b, is_signed may change freely after E0 without affecting the result.
- No overflow output: the 64-bit product is always exact.

Test Plan:
- Unsigned small: start, is_signed=0, a=6, b=7.
  -> done exactly 33 edges later; hi=0x00000000, lo=0x0000002A; busy high for 33 cycles.
- Signed mixed: is_signed=1, a=0xFFFFFFFD (-3), b=5.
  -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Extremes:
  - Unsigned a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
  - Signed a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
  - Signed a=0x80000000, b=1 -> hi=0xFFFFFFFF, lo=0x80000000.
- start re-asserted with a=2, b=2 at cycle 10 of a 6x7 operation.
  -> ignored; result lo=0x2A.
- start held high continuously.
  -> second operation begins on the edge where done=1; second done arrives 34 cycles after the first.
- rst_n pulled low at cycle 15 of an operation.
  -> busy, done, hi, lo go to 0 immediately (asynchronously).
  -> no done pulse follows.
  -> a fresh 6x7 after release gives lo=0x2A.
